// File: rtl/mem_sys_resp.sv
// Multi-cycle data-memory responder for the MEM stage.
// A legal request is latched and served after LATENCY cycles. The pipeline is
// held with a combinational stall until the completion cycle, where done
// pulses. Illegal requests are rejected with a one-cycle err pulse and never
// touch the array.
module mem_sys_resp #(
  parameter int LATENCY = 4,  // request-to-done cycles, 2..15
  parameter int AW      = 8   // word-address bits
) (
  input  logic        clk,
  input  logic        rst,       // asynchronous, active-low
  input  logic [15:0] addr,      // byte address, word index addr[AW:1]
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [AW-1:0] lat_addr;
  logic [15:0]   lat_data;
  logic          lat_wr;

  logic [15:0]   mem [2**AW];

  logic accepting;
  logic req_legal;
  logic req_illegal;
  logic start;
  logic reject;
  logic finish;

  // DONE accepts new work exactly like IDLE, which allows back-to-back requests.
  assign accepting   = (state == S_IDLE) || (state == S_DONE);
  assign req_legal   = (rd ^ wr) & ~addr[0];
  assign req_illegal = (rd | wr) & ~req_legal;
  assign start       = accepting & req_legal;
  assign reject      = accepting & req_illegal;
  assign finish      = (state == S_BUSY) && (cnt <= 4'd1);

  // Hold the pipeline from the accepting cycle through the last BUSY cycle;
  // forced low while reset is asserted regardless of rd/wr.
  assign stall = rst & (start | (state == S_BUSY));

  // High byte-address bits beyond the array alias onto lower words.
  if (AW < 15) begin : g_alias
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[15:AW+1];
  end

  // Control FSM, latency counter, request latch and read-data register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      lat_addr <= '0;
      lat_data <= 16'h0000;
      lat_wr   <= 1'b0;
      data_out <= 16'h0000;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_BUSY;
            cnt      <= CNT_LOAD;
            lat_addr <= addr[AW:1];
            lat_data <= data_in;
            lat_wr   <= wr;
          end else begin
            state <= S_IDLE;
            err   <= reject;
          end
        end
        S_BUSY: begin
          if (finish) begin
            state <= S_DONE;
            cnt   <= 4'd0;
            done  <= 1'b1;
            if (!lat_wr) data_out <= mem[lat_addr];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write commit on the edge that enters DONE, from latched address/data only.
  // NOTE: the array has no reset; a reset mid-transaction forces the FSM to
  // IDLE, so a pending write can never reach this enable.
  always_ff @(posedge clk) begin
    if (finish && lat_wr) mem[lat_addr] <= lat_data;
  end

endmodule

// File: tb/tb_mem_sys_resp.sv
// Directed bench for mem_sys_resp: the driver pushes expected responses into a
// scoreboard queue; an independent monitor pops and compares on done/err.
module tb_mem_sys_resp;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        rd;
  logic        wr;
  logic [15:0] data_out;
  logic        stall;
  logic        done;
  logic        err;

  typedef struct packed {
    logic        is_err;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  mem_sys_resp #(.LATENCY(LAT), .AW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .rd       (rd),
    .wr       (wr),
    .data_out (data_out),
    .stall    (stall),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one request at posedge+1; returns at posedge+1 of the completion
  // cycle (done cycle for legal, err cycle for illegal).
  task automatic issue(input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input bit legal,
                       input logic [15:0] exp_data, input bit scramble);
    exp_t e;
    rd = r; wr = w; addr = a; data_in = d;
    @(negedge clk);
    check("stall_c0", {31'd0, stall}, {31'd0, legal});
    e.is_err = !legal;
    e.data   = exp_data;
    sb.push_back(e);
    @(posedge clk); #1;
    if (scramble) begin
      rd = 1'b0; wr = 1'b1; addr = 16'h0002; data_in = 16'hFFFF;
    end else begin
      rd = 1'b0; wr = 1'b0;
    end
    if (legal) begin
      for (int i = 1; i < LAT; i++) begin
        @(negedge clk);
        check("stall_busy", {31'd0, stall}, 32'd1);
        check("done_early", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
      end
      rd = 1'b0; wr = 1'b0;
    end
  endtask

  task automatic idle_cycle();
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    check("stall_idle", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: every done/err pulse must match the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && (done === 1'b1 || err === 1'b1)) begin
        check("done_err_excl", {31'd0, done & err}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_resp", {30'd0, done, err}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("resp_kind_err", {31'd0, err}, {31'd0, e.is_err});
          check("resp_data", {16'd0, data_out}, {16'd0, e.data});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rd = 1'b1; wr = 1'b0; addr = 16'h0000; data_in = 16'h0000;
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_data_out", {16'd0, data_out}, 32'h0000);
    @(posedge clk); #1;
    rst = 1'b1; rd = 1'b0;

    // Write then read back, accepted in the first cycle after reset.
    issue(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b1, 16'h0000, 1'b0);
    idle_cycle();
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF, 1'b0);
    idle_cycle();

    // rd and wr both high: err pulse, data_out unchanged.
    issue(1'b1, 1'b1, 16'h0020, 16'h0000, 1'b0, 16'hBEEF, 1'b0);
    idle_cycle();

    // Odd read address: err pulse.
    issue(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 16'hBEEF, 1'b0);
    idle_cycle();

    // Aliased write to word 0, read back-to-back from the DONE cycle.
    issue(1'b0, 1'b1, 16'h0200, 16'h1234, 1'b1, 16'hBEEF, 1'b0);
    issue(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234, 1'b0);
    idle_cycle();

    // Inputs changed during BUSY must not affect the latched write.
    issue(1'b0, 1'b1, 16'h0002, 16'h7777, 1'b1, 16'h1234, 1'b0);
    idle_cycle();
    issue(1'b0, 1'b1, 16'h0030, 16'h4321, 1'b1, 16'h1234, 1'b1);
    idle_cycle();
    issue(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 16'h4321, 1'b0);
    idle_cycle();
    issue(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 16'h7777, 1'b0);
    idle_cycle();

    // Reset in C2 of a write aborts it; the earlier value survives.
    issue(1'b0, 1'b1, 16'h0040, 16'hAAAA, 1'b1, 16'h7777, 1'b0);
    idle_cycle();
    rd = 1'b0; wr = 1'b1; addr = 16'h0040; data_in = 16'h5555;
    @(posedge clk); #1;
    wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);
    check("midrst_data_out", {16'd0, data_out}, 32'h0000);
    @(posedge clk); #1;
    rst = 1'b1;
    issue(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 16'hAAAA, 1'b0);
    idle_cycle();

    // Odd write to 0x0041 (same word index as 0x0040) must not write.
    issue(1'b0, 1'b1, 16'h0041, 16'h9999, 1'b0, 16'hAAAA, 1'b0);
    idle_cycle();
    issue(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 16'hAAAA, 1'b0);
    idle_cycle();

    repeat (3) idle_cycle();
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_sys_resp.md
MEM_SYS_RESP -- requirements
Module: mem_sys_resp

Interface
REQ-001 Parameter LATENCY, default 4: cycles from request to done; legal range 2..15.
REQ-002 Parameter AW, default 8: word-address bits; array depth 2^AW x 16.
REQ-003 Port clk  in  1: single clock; all state updates on rising edge.
REQ-004 Port rst  in  1: reset, asynchronous, active-low.
REQ-005 Port addr  in  16: byte address; word index is addr[AW:1]; addr[15:AW+1] ignored (aliasing).
REQ-006 Port data_in  in  16: write data.
REQ-007 Port rd  in  1: read request.
REQ-008 Port wr  in  1: write request.
REQ-009 Port data_out  out  16: last completed read data; feeds the data_mem_in input of the MEM/WB register.
REQ-010 Port stall  out  1: pipeline hold request (combinational).
REQ-011 Port done  out  1: one-cycle completion pulse (registered).
REQ-012 Port err  out  1: one-cycle illegal-request pulse (registered).

Function
REQ-013 FSM states: IDLE, BUSY, DONE; DONE shall accept new requests exactly as IDLE does.
REQ-014 Legal request: exactly one of rd/wr high and addr[0]==0.
REQ-015 Illegal request: rd&wr both high, or (rd|wr) with addr[0]==1.
REQ-016 Legal request in IDLE/DONE during cycle C0: latch addr, data_in and op at the C0 edge; enter BUSY.
REQ-017 stall: high combinationally in C0 and in every BUSY cycle C1..C0+LATENCY-1; low otherwise.
REQ-018 done: high only in cycle C0+LATENCY; stall low in that cycle.
REQ-019 Write commit: array word written at the edge that enters DONE, using latched addr/data only.
REQ-020 Read: data_out updated at the edge that enters DONE; holds its value until the next read completes; writes never change data_out.
REQ-021 rd, wr, addr, data_in in BUSY: ignored; the latched copy governs the transaction.
REQ-022 Illegal request in IDLE/DONE during C0: no array access, stall low, err high in C0+1 only, next state IDLE.
REQ-023 Back-to-back: legal request present in a DONE cycle is accepted as the new C0; done low in the following cycle, stall high.
REQ-024 Latency counter: loads LATENCY-1 on accept and decrements in BUSY; transition to DONE on the edge where it equals 1; no wrap-around.
REQ-025 Read after write to the same word, issued back-to-back: read returns the newly written data.
REQ-026 done and err shall never be high in the same cycle.

Reset
REQ-027 rst low: state IDLE, counter 0, data_out 0x0000, done 0, err 0, stall 0 (independent of rd/wr).
REQ-028 Reset asserted mid-transaction: transaction aborted; a pending write is not committed.
REQ-029 Array contents are not reset; values are undefined until written.
REQ-030 After rst deasserts, a legal request is accepted in the first clocked cycle.

Verification
REQ-031 Write 0xBEEF to addr 0x0010, then read 0x0010 -> stall high for 4 cycles, done in cycle 5 of each transaction, data_out=0xBEEF after the read.
REQ-032 Request with rd=wr=1, addr 0x0020 -> stall 0, err pulse next cycle, no done, data_out unchanged.
REQ-033 Read addr 0x0003 (odd) -> err pulse, array unchanged, state IDLE.
REQ-034 Write 0x1234 to addr 0x0200 with AW=8 (aliases word 0), then read 0x0000 -> data_out=0x1234.
REQ-035 Write 0x5555 to addr 0x0040; assert rst in cycle C2; after release, read 0x0040 -> data_out is not 0x5555 (pre-written 0xAAAA retained), data_out=0x0000 after reset.
REQ-036 During BUSY of a write, change addr/data_in to 0x0002/0xFFFF -> latched address and data are written; word 0x0002 is unchanged.
